// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Hazard controller for the 5-stage RISC-V pipeline. It sits beside the ID/EX
// register and does four jobs:
//   * Operand forwarding for NUM_SRC EX-stage sources. The three producers are
//     EX/MEM, MEM/WB and a one-cycle write-back hold stage. The first match in
//     that order wins, and register x0 is never forwarded.
//   * Load-use detection and a stall FSM that inserts LOAD_LAT bubbles.
//   * A global freeze while the data memory is busy. The FSM, the hold stage
//     and the forwarding selects keep their values during the freeze.
//   * A saturating count of cycles in which the PC was not updated.
//
// Ports
//   clk            : core clock, rising edge
//   arst           : asynchronous reset, active-high
//   ex_rs          : ID/EX source indices; operand i = [i*REG_ADDR_W +: REG_ADDR_W]
//   id_rs          : IF/ID source indices, same packing
//   id_ex_rd       : ID/EX destination
//   id_ex_mem_read : ID/EX instruction is a load
//   ex_mem_rd      : EX/MEM destination
//   ex_mem_regwr   : EX/MEM writes the register file
//   mem_wb_rd      : MEM/WB destination
//   mem_wb_regwr   : MEM/WB writes the register file
//   mem_busy       : data memory not ready; freeze the pipeline
//   fwd_sel        : per-operand mux select, operand i = [2*i +: 2]
//                    (10 EX/MEM, 01 MEM/WB, 11 hold stage, 00 register file)
//   pc_write_en    : PC update enable
//   if_id_write_en : IF/ID update enable
//   id_ex_flush    : insert a bubble into ID/EX
//   pipe_freeze    : hold all pipeline registers
//   stall_cycles   : saturating count of cycles with pc_write_en = 0
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0]         id_ex_rd,
  input  logic                          id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
  input  logic                          ex_mem_regwr,
  input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
  input  logic                          mem_wb_regwr,
  input  logic                          mem_busy,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          pc_write_en,
  output logic                          if_id_write_en,
  output logic                          id_ex_flush,
  output logic                          pipe_freeze,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_HOLD   = 2'b11;

  // The first bubble is issued from IDLE. STALL only covers the remaining
  // LOAD_LAT-1 bubbles, so a single-bubble load never leaves IDLE.
  localparam bit         MULTI_BUBBLE = (LOAD_LAT > 1);
  localparam logic [2:0] CNT_INIT     = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg, cnt_next;
  logic                    hold_valid_reg;
  logic [REG_ADDR_W-1:0]   hold_rd_reg;
  logic [2*NUM_SRC-1:0]    fwd_sel_reg;
  logic [CNT_W-1:0]        stall_cnt_reg;

  logic [2*NUM_SRC-1:0]    fwd_live;
  logic [NUM_SRC-1:0]      hz_vec;
  logic                    hz;
  logic                    stall_now;

  // ---------------------------------------------------------------------------
  // Forwarding selects, one priority chain per EX source operand
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
      logic [REG_ADDR_W-1:0] rs;
      logic                  hit_ex_mem;
      logic                  hit_mem_wb;
      logic                  hit_hold;

      assign rs         = ex_rs[gi*REG_ADDR_W +: REG_ADDR_W];
      assign hit_ex_mem = ex_mem_regwr   && (ex_mem_rd   != '0) && (ex_mem_rd   == rs);
      assign hit_mem_wb = mem_wb_regwr   && (mem_wb_rd   != '0) && (mem_wb_rd   == rs);
      assign hit_hold   = hold_valid_reg && (hold_rd_reg != '0) && (hold_rd_reg == rs);

      assign fwd_live[2*gi +: 2] = hit_ex_mem ? FWD_EX_MEM :
                                   hit_mem_wb ? FWD_MEM_WB :
                                   hit_hold   ? FWD_HOLD   :
                                                FWD_RF;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load-use hazard: a load in ID/EX targets a source of the IF/ID instruction
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_hz
      assign hz_vec[gi] = id_ex_mem_read && (id_ex_rd != '0) &&
                          (id_ex_rd == id_rs[gi*REG_ADDR_W +: REG_ADDR_W]);
    end
  endgenerate

  assign hz = |hz_vec;

  // In STALL the remaining bubbles are issued whatever hz is doing.
  assign stall_now = (state_reg == ST_STALL) || hz;

  // ---------------------------------------------------------------------------
  // Stall FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall FSM: next-state logic. A freeze holds both the state and cnt.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!mem_busy) begin
      case (state_reg)
        ST_IDLE: begin
          if (hz && MULTI_BUBBLE) begin
            state_next = ST_STALL;
            cnt_next   = CNT_INIT;
          end
        end
        ST_STALL: begin
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stall FSM: outputs. Reset has priority so that all outputs go inactive as
  // soon as arst rises, without waiting for a clock edge. A freeze outranks a
  // stall: no bubble is inserted while the whole pipe is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_sel        = fwd_live;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_flush    = 1'b0;
    pipe_freeze    = 1'b0;
    if (arst) begin
      fwd_sel = '0;
    end else if (mem_busy) begin
      pipe_freeze    = 1'b1;
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      fwd_sel        = fwd_sel_reg;
    end else if (stall_now) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back hold stage and frozen forwarding select. Both advance only on
  // non-frozen cycles. fwd_sel_reg therefore holds the select from the last
  // cycle the EX stage actually consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hold_valid_reg <= 1'b0;
      hold_rd_reg    <= '0;
      fwd_sel_reg    <= '0;
    end else if (!mem_busy) begin
      hold_valid_reg <= mem_wb_regwr;
      hold_rd_reg    <= mem_wb_rd;
      fwd_sel_reg    <= fwd_live;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall statistics. Both bubbles and freeze cycles count. The counter sticks
  // at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_reg <= '0;
    end else if (!pc_write_en && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// how many bubbles are still owed, the last write-back destination and the
// stall tally. Every cycle, each DUT output is compared with that model.
// -----------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

  localparam int RW   = 5;
  localparam int NS   = 2;
  localparam int LL   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [NS*RW-1:0] ex_rs, id_rs;
  logic [RW-1:0]   id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic            id_ex_mem_read, ex_mem_regwr, mem_wb_regwr, mem_busy;
  logic [2*NS-1:0] fwd_sel;
  logic            pc_write_en, if_id_write_en, id_ex_flush, pipe_freeze;
  logic [CW-1:0]   stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              m_bubbles;
  int              m_count;
  bit              m_hold_v;
  logic [RW-1:0]   m_hold_rd;
  logic [2*NS-1:0] m_fwd_prev;
  logic [2*NS-1:0] m_fwd_live;
  bit              m_hz;
  logic [2*NS-1:0] e_fwd;
  logic            e_pc, e_flush, e_freeze;

  // Per-scenario tallies of observed behaviour
  int pc_low_n, freeze_n, flush_n, flush_frz_n;

  hazard_forward_ctrl #(
    .REG_ADDR_W(RW), .NUM_SRC(NS), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .clk(clk), .arst(arst),
    .ex_rs(ex_rs), .id_rs(id_rs), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwr(ex_mem_regwr),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwr(mem_wb_regwr),
    .mem_busy(mem_busy),
    .fwd_sel(fwd_sel), .pc_write_en(pc_write_en),
    .if_id_write_en(if_id_write_en), .id_ex_flush(id_ex_flush),
    .pipe_freeze(pipe_freeze), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_rs = '0; id_rs = '0; id_ex_rd = '0; id_ex_mem_read = 1'b0;
    ex_mem_rd = '0; ex_mem_regwr = 1'b0; mem_wb_rd = '0; mem_wb_regwr = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic model_reset();
    m_bubbles = 0; m_count = 0; m_hold_v = 0; m_hold_rd = '0; m_fwd_prev = '0;
  endtask

  task automatic clear_tallies();
    pc_low_n = 0; freeze_n = 0; flush_n = 0; flush_frz_n = 0;
  endtask

  // Work out what the outputs should be this cycle from the rules.
  task automatic model_eval();
    logic [RW-1:0] p_rd[3];
    bit            p_v[3];
    logic [1:0]    p_code[3];
    logic [RW-1:0] rs;
    bit            stall;
    p_rd   = '{ex_mem_rd, mem_wb_rd, m_hold_rd};
    p_v    = '{ex_mem_regwr, mem_wb_regwr, m_hold_v};
    p_code = '{2'b10, 2'b01, 2'b11};
    m_hz = 0;
    for (int j = 0; j < NS; j++)
      if (id_ex_mem_read && id_ex_rd != 0 && id_ex_rd == id_rs[j*RW +: RW]) m_hz = 1;
    for (int i = 0; i < NS; i++) begin
      rs = ex_rs[i*RW +: RW];
      m_fwd_live[2*i +: 2] = 2'b00;
      // Walk from lowest to highest priority so that the best match is written last.
      for (int p = 2; p >= 0; p--)
        if (p_v[p] && p_rd[p] != 0 && p_rd[p] == rs) m_fwd_live[2*i +: 2] = p_code[p];
    end
    if (arst) begin
      e_fwd = '0; e_pc = 1'b1; e_flush = 1'b0; e_freeze = 1'b0;
    end else if (mem_busy) begin
      e_fwd = m_fwd_prev; e_pc = 1'b0; e_flush = 1'b0; e_freeze = 1'b1;
    end else begin
      stall = (m_bubbles > 0) || m_hz;
      e_fwd = m_fwd_live; e_pc = !stall; e_flush = stall; e_freeze = 1'b0;
    end
  endtask

  task automatic model_check();
    model_eval();
    check("fwd_sel", 32'(fwd_sel), 32'(e_fwd));
    check("pc_write_en", 32'(pc_write_en), 32'(e_pc));
    check("if_id_write_en", 32'(if_id_write_en), 32'(e_pc));
    check("id_ex_flush", 32'(id_ex_flush), 32'(e_flush));
    check("pipe_freeze", 32'(pipe_freeze), 32'(e_freeze));
    check("stall_cycles", 32'(stall_cycles), 32'(m_count));
    if (pc_write_en === 1'b0) pc_low_n++;
    if (pipe_freeze === 1'b1) freeze_n++;
    if (id_ex_flush === 1'b1) flush_n++;
    if (pipe_freeze === 1'b1 && id_ex_flush === 1'b1) flush_frz_n++;
  endtask

  task automatic settle();
    #2;
    model_check();
  endtask

  // Clock edge: advance the model with the inputs of the cycle just checked.
  task automatic tick();
    @(posedge clk);
    if (!arst) begin
      if (!e_pc && m_count < CMAX) m_count++;
      if (!mem_busy) begin
        if (m_bubbles > 0) m_bubbles--;
        else if (m_hz) m_bubbles = LL - 1;
        m_hold_v   = mem_wb_regwr;
        m_hold_rd  = mem_wb_rd;
        m_fwd_prev = m_fwd_live;
      end
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic pulse_reset();
    arst = 1'b1;
    #1;
    model_reset();
    model_check();
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic load_hazard();
    id_ex_mem_read = 1'b1;
    id_ex_rd = 5'd9;
    id_rs[RW +: RW] = 5'd9;
  endtask

  initial begin
    // Reset state
    idle();
    model_reset();
    clear_tallies();
    #3;
    model_check();
    check("reset_fwd", 32'(fwd_sel), 32'h0);
    check("reset_pc", 32'(pc_write_en), 32'h1);
    check("reset_cnt", 32'(stall_cycles), 32'h0);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // EX/MEM takes priority over MEM/WB
    idle();
    ex_mem_regwr = 1'b1; ex_mem_rd = 5'd5; mem_wb_regwr = 1'b1; mem_wb_rd = 5'd5;
    ex_rs[0 +: RW] = 5'd5;
    settle();
    check("t1_prio_exmem", 32'(fwd_sel[1:0]), 32'h2);
    tick();

    // x0 is never forwarded
    idle();
    ex_mem_regwr = 1'b1; ex_mem_rd = 5'd0; mem_wb_regwr = 1'b1; mem_wb_rd = 5'd0;
    ex_rs[RW +: RW] = 5'd0;
    settle();
    check("t2_x0", 32'(fwd_sel[3:2]), 32'h0);
    tick();

    // The hold stage supplies a write-back from the previous cycle
    idle();
    mem_wb_regwr = 1'b1; mem_wb_rd = 5'd7;
    cycle();
    idle();
    ex_rs[0 +: RW] = 5'd7;
    settle();
    check("t3_hold", 32'(fwd_sel[1:0]), 32'h3);
    tick();

    // Load-use with LOAD_LAT = 3: three bubbles
    idle();
    pulse_reset();
    clear_tallies();
    load_hazard();
    cycle();
    idle();
    repeat (5) cycle();
    check("t4_pc_low", 32'(pc_low_n), 32'd3);
    check("t4_stall_cycles", 32'(stall_cycles), 32'd3);

    // Freeze in the middle of a stall
    idle();
    pulse_reset();
    clear_tallies();
    load_hazard();
    cycle();
    idle();
    mem_busy = 1'b1;
    repeat (4) cycle();
    mem_busy = 1'b0;
    repeat (4) cycle();
    check("t5_freeze", 32'(freeze_n), 32'd4);
    check("t5_flush_frozen", 32'(flush_frz_n), 32'd0);
    check("t5_bubbles", 32'(flush_n), 32'd3);
    check("t5_stall_cycles", 32'(stall_cycles), 32'd7);

    // Reset while in STALL
    idle();
    pulse_reset();
    load_hazard();
    cycle();
    ex_mem_regwr = 1'b1; ex_mem_rd = 5'd3; ex_rs[0 +: RW] = 5'd3; mem_busy = 1'b1;
    arst = 1'b1;
    #1;
    model_reset();
    check("t6_pc", 32'(pc_write_en), 32'h1);
    check("t6_flush", 32'(id_ex_flush), 32'h0);
    check("t6_freeze", 32'(pipe_freeze), 32'h0);
    check("t6_fwd", 32'(fwd_sel), 32'h0);
    check("t6_cnt", 32'(stall_cycles), 32'h0);
    idle();
    @(posedge clk);
    #1;
    arst = 1'b0;
    settle();
    check("t6_idle_pc", 32'(pc_write_en), 32'h1);
    tick();

    // The stall counter saturates at all-ones
    idle();
    pulse_reset();
    mem_busy = 1'b1;
    repeat (CMAX + 5) cycle();
    check("t7_saturate", 32'(stall_cycles), 32'(CMAX));
    idle();
    cycle();

    // Randomized traffic. Register indices are kept small so that matches are common.
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) begin
        ex_rs[i*RW +: RW] = RW'($urandom_range(0, 3));
        id_rs[i*RW +: RW] = RW'($urandom_range(0, 3));
      end
      id_ex_rd       = RW'($urandom_range(0, 3));
      id_ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_mem_rd      = RW'($urandom_range(0, 3));
      ex_mem_regwr   = 1'($urandom_range(0, 1));
      mem_wb_rd      = RW'($urandom_range(0, 3));
      mem_wb_regwr   = 1'($urandom_range(0, 1));
      mem_busy       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
